// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4x4 unsigned multiplier
// (tt_um_mult) among NREQ requesters, with registered operands, a registered
// product and a valid/ready response channel tagged with the requester ID.
// Optional build macro MULT_SHARE_ARB_BYPASS_EN: when defined, the round-robin
// arbitration also runs in RESP during the cycle the response is accepted, so
// back-to-back operations take 2 cycles instead of 3.

module tt_um_mult (
   input  logic [3:0] X,
   input  logic [3:0] Y,
   output logic [7:0] Z2
);
   assign Z2 = {4'b0, X} * {4'b0, Y};
endmodule

module mult_share_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_x,
   input  logic [4*NREQ-1:0]    req_y,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [7:0]           rsp_data,
   output logic [ID_W-1:0]      rsp_id,
   input  logic                 rsp_ready
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [3:0]        x_q, x_d, y_q, y_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

   logic              found;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W:0]     sum;
   logic              arb_en;
   logic              grant;
   logic [7:0]        z2;

   // Single shared multiplier, fed only from the latched operands.
   tt_um_mult u_mult (
      .X  (x_q),
      .Y  (y_q),
      .Z2 (z2)
   );

   // Round-robin search: first valid requester at or after rr_q, wrapping.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
         if (!found && req_valid[sum[ID_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = sum[ID_W-1:0];
         end
      end
   end

`ifdef MULT_SHARE_ARB_BYPASS_EN
   assign arb_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
`else
   assign arb_en = (state_q == IDLE);
`endif

   // A grant is never offered while reset is asserted.
   assign grant = arb_en && found && !rst;

   // One-hot ready toward the winning requester.
   always_comb begin
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   // Next-state logic: arbitrate/latch, compute, hold response until taken.
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      x_d         = x_q;
      y_d         = y_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: ;
         CALC: begin
            rsp_data_d  = z2;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Grant only fires in IDLE, or in RESP on acceptance when bypass is built.
      if (grant) begin
         x_d     = req_x[4*gnt_idx +: 4];
         y_d     = req_y[4*gnt_idx +: 4];
         id_d    = gnt_idx;
         rr_d    = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         state_d = CALC;
      end
   end

   // State registers with synchronous reset; reset drops any in-flight result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model (pending-response queue with due
// cycles, round-robin pointer as an integer).
module tb_mult_share_arbiter;
   localparam int NREQ = 4;
   localparam int ID_W = 2;
`ifdef MULT_SHARE_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [4*NREQ-1:0]   req_x, req_y;
   logic [NREQ-1:0]     req_ready;
   logic                rsp_valid;
   logic [7:0]          rsp_data;
   logic [ID_W-1:0]     rsp_id;
   logic                rsp_ready;

   always #5 clk = ~clk;

   mult_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready)
   );

   typedef struct {int d; int id; int due;} ent_t;
   ent_t q[$];
   int total = 0, bad = 0;
   int cyc = 0, ptr = 0, last_d = 0, last_id = 0;
   logic [NREQ-1:0] pend;
   int px[NREQ], py[NREQ];
   logic rr;
   logic [NREQ-1:0] seen_rdy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive at posedge+1, model and check at negedge.
   task automatic step(input bit do_rst);
      bit exp_v, pop, free;
      int exp_d, exp_id, g, idx;
      logic [NREQ-1:0] exp_rdy;
      rst = do_rst;
      req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         req_x[4*i +: 4] = 4'(px[i]);
         req_y[4*i +: 4] = 4'(py[i]);
      end
      rsp_ready = rr;
      @(negedge clk);
      seen_rdy = req_ready;
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      exp_d = exp_v ? q[0].d : last_d;
      exp_id = exp_v ? q[0].id : last_id;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("rsp_id", 32'(rsp_id), 32'(exp_id));
      if (do_rst) begin
         chk("req_ready_rst", 32'(req_ready), 32'd0);
         q.delete();
         ptr = 0; last_d = 0; last_id = 0;
      end else begin
         pop = exp_v && rr;
         free = (q.size() == 0) || (BYP && pop);
         g = -1;
         if (free) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (ptr + k) % NREQ;
               if (g < 0 && pend[idx]) g = idx;
            end
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (exp_v) begin last_d = q[0].d; last_id = q[0].id; end
         if (pop) void'(q.pop_front());
         if (g >= 0) begin
            q.push_back('{d: px[g] * py[g], id: g, due: cyc + 2});
            ptr = (g + 1) % NREQ;
            pend[g] = 1'b0;
         end
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic drain(input int n);
      repeat (n) begin pend = '0; rr = 1'b1; step(1'b0); end
   endtask

   initial begin
      int ng, n;
      logic [NREQ-1:0] g_first;
      rst = 1'b1; pend = '0; rr = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin px[i] = 0; py[i] = 0; end
      repeat (2) @(posedge clk);
      #1;
      // reset state with requests present
      pend = '1; step(1'b1);

      // single op, latency and max product
      pend = 4'b0010; px[1] = 15; py[1] = 15; rr = 1'b1;
      step(1'b0);
      chk("t1_gnt", 32'(seen_rdy), 32'd2);
      step(1'b0);
      chk("t1_vld", 32'(rsp_valid), 32'd1);
      chk("t1_data", 32'(rsp_data), 32'd225);
      chk("t1_id", 32'(rsp_id), 32'd1);
      step(1'b0);
      chk("t1_vld_off", 32'(rsp_valid), 32'd0);

      // all requesting, round-robin order from reset
      drain(3); pend = '0; step(1'b1);
      for (int i = 0; i < NREQ; i++) begin px[i] = i + 2; py[i] = 13 - i; end
      repeat (20) begin pend = '1; rr = 1'b1; step(1'b0); end

      // backpressure
      drain(4);
      pend = 4'b0010; px[1] = 9; py[1] = 7; rr = 1'b0;
      step(1'b0);
      pend = 4'b1101;
      step(1'b0);
      repeat (6) begin
         chk("bp_data", 32'(rsp_data), 32'd63);
         chk("bp_id", 32'(rsp_id), 32'd1);
         step(1'b0);
      end
      rr = 1'b1; g_first = '0;
      repeat (3) begin
         step(1'b0);
         if (g_first == '0 && seen_rdy != '0) g_first = seen_rdy;
      end
      chk("bp_next", 32'(g_first), 32'd4);

      // reset in CALC aborts the op and resets the pointer
      drain(6);
      pend = 4'b0100; px[2] = 11; py[2] = 5;
      step(1'b0);
      pend = '0;
      step(1'b1);
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      pend = 4'b1001;
      step(1'b0);
      chk("rst_rr", 32'(seen_rdy), 32'd1);

      // exhaustive products on requester 3
      drain(6);
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            px[3] = x; py[3] = y; pend = 4'b1000; rr = 1'b1; n = 0;
            while (pend[3] && n < 6) begin step(1'b0); n++; end
            chk("ex_gnt", 32'(pend[3]), 32'd0);
         end
      end

      // throughput with two requesters held
      drain(6);
      ng = 0;
      repeat (12) begin
         pend = 4'b0011; rr = 1'b1; step(1'b0);
         if (seen_rdy != '0) ng++;
      end
      chk("thru", 32'(ng), BYP ? 32'd6 : 32'd4);

      // random traffic
      drain(4);
      repeat (3000) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               px[i] = int'($urandom_range(15));
               py[i] = int'($urandom_range(15));
            end else if (pend[i] && $urandom_range(19) == 0) begin
               pend[i] = 1'b0;
            end
         end
         rr = ($urandom_range(3) != 0);
         step($urandom_range(99) == 0);
      end
      drain(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
